// File: rtl/boid_frame_scheduler_pkg.sv
// Shared boid display constants and the frame scheduler state encoding.
package boids_pkg;
  localparam int VIDEO_WIDTH    = 640;
  localparam int VIDEO_HEIGHT   = 480;
  localparam int PIXEL_COUNT    = VIDEO_WIDTH * VIDEO_HEIGHT;
  localparam int MAX_BOIDS      = 16;
  localparam int BITS_FOR_BOIDS = $clog2(MAX_BOIDS);
  localparam int ADDR_WIDTH     = $clog2(PIXEL_COUNT) + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWAP  = 2'd1,
    ST_SCAN  = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;
endpackage

// File: rtl/boid_frame_scheduler_if.sv
// Frame scheduler bundle: VGA frame strobe, BPU select mux side and display-RAM write side.
interface boid_frame_scheduler_if import boids_pkg::*; #(
  parameter int BOID_BITS = BITS_FOR_BOIDS,
  parameter int ADDR_W    = ADDR_WIDTH
);
  logic                  screen_end;
  logic [BOID_BITS:0]    num_boids;
  logic [ADDR_W-1:0]     boid_addr_in;
  logic                  overrun_clr;
  logic [BOID_BITS-1:0]  boid_sel;
  logic                  disp_swap;
  logic                  disp_we;
  logic [ADDR_W-1:0]     disp_waddr;
  logic                  busy;
  logic [15:0]           frame_count;
  logic                  overrun;

  modport master (
    input  screen_end, num_boids, boid_addr_in, overrun_clr,
    output boid_sel, disp_swap, disp_we, disp_waddr, busy, frame_count, overrun
  );
  modport slave (
    output screen_end, num_boids, boid_addr_in, overrun_clr,
    input  boid_sel, disp_swap, disp_we, disp_waddr, busy, frame_count, overrun
  );
endinterface

// File: rtl/boid_frame_scheduler_edge_detect_rise.sv
// Registered 1-bit rising-edge detector.
// Latency: rise is combinational from d against the previous-cycle value.
// Backpressure: none; a level held high yields a single rise.
module edge_detect_rise (
  input  logic clock,
  input  logic resetn,
  input  logic d,
  output logic rise
);
  logic d_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) d_q <= 1'b0;
    else         d_q <= d;
  end

  assign rise = d & ~d_q;
endmodule

// File: rtl/boid_frame_scheduler.sv
// Per-frame display RAM refresh: swap pulse, one boid per cycle scan, one write per in-range boid.
// Latency: n boids take n+3 cycles from edge detect back to idle; writes trail boid_sel by one cycle.
// Backpressure: none; frame edges arriving while busy only set the sticky overrun flag.
module boid_frame_scheduler #(
  parameter int MAX_BOIDS   = 16,
  parameter int BOID_BITS   = 4,
  parameter int PIXEL_COUNT = 307200,
  parameter int ADDR_WIDTH  = 20
) (
  input  logic                  clock,
  input  logic                  resetn,
  boid_frame_scheduler_if.master bus
);
  import boids_pkg::*;

  localparam logic [BOID_BITS:0]    N_CAP   = (BOID_BITS+1)'(MAX_BOIDS);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LIM = ADDR_WIDTH'(PIXEL_COUNT);

  state_t             state, state_nxt;
  logic               frame_rise;
  logic [BOID_BITS:0] n_lat;
  logic               last_boid;

  edge_detect_rise u_screen_end_edge (
    .clock  (clock),
    .resetn (resetn),
    .d      (bus.screen_end),
    .rise   (frame_rise)
  );

  assign last_boid = ({1'b0, bus.boid_sel} == n_lat - (BOID_BITS+1)'(1));

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    bus.disp_swap = 1'b0;
    bus.busy      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (frame_rise) state_nxt = ST_SWAP;
      end
      ST_SWAP: begin
        bus.disp_swap = 1'b1;
        bus.busy      = 1'b1;
        state_nxt     = (n_lat != '0) ? ST_SCAN : ST_FLUSH;
      end
      ST_SCAN: begin
        bus.busy = 1'b1;
        if (last_boid) state_nxt = ST_FLUSH;
      end
      ST_FLUSH: begin
        bus.busy  = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Boid index, write pipeline and frame accounting.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      n_lat           <= '0;
      bus.boid_sel    <= '0;
      bus.disp_we     <= 1'b0;
      bus.disp_waddr  <= '0;
      bus.frame_count <= '0;
    end else begin
      bus.disp_we <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (frame_rise) begin
            n_lat        <= (bus.num_boids > N_CAP) ? N_CAP : bus.num_boids;
            bus.boid_sel <= '0;
          end
        end
        ST_SCAN: begin
          bus.disp_we    <= (bus.boid_addr_in < ADDR_LIM);
          bus.disp_waddr <= bus.boid_addr_in;
          if (!last_boid) bus.boid_sel <= bus.boid_sel + BOID_BITS'(1);
        end
        ST_FLUSH: bus.frame_count <= bus.frame_count + 16'd1;
        default: ;
      endcase
    end
  end

  // A new overrun in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)                           bus.overrun <= 1'b0;
    else if (frame_rise && state != ST_IDLE) bus.overrun <= 1'b1;
    else if (bus.overrun_clr)              bus.overrun <= 1'b0;
  end
endmodule

// File: tb/tb_boid_frame_scheduler.sv
// Randomised and directed bench for boid_frame_scheduler against a frame-timeline model.
module tb_boid_frame_scheduler;
  import boids_pkg::*;

  logic clock = 1'b0;
  logic resetn;

  boid_frame_scheduler_if bif ();

  boid_frame_scheduler #(
    .MAX_BOIDS   (16),
    .BOID_BITS   (4),
    .PIXEL_COUNT (307200),
    .ADDR_WIDTH  (20)
  ) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bif.master)
  );

  always #5 clock = ~clock;

  // BPU array stand-in: each boid's pixel address, muxed by boid_sel.
  logic [19:0] addr_tab [16];
  always_comb bif.boid_addr_in = addr_tab[bif.boid_sel];

  int checks   = 0;
  int failures = 0;

  // Model: a frame is described only by its start cycle, boid count and address snapshot.
  int          cyc = 0;
  bit          m_active;
  int          m_s, m_n, m_fc;
  bit          m_ov, m_prev;
  logic [19:0] m_tab [16];

  int          tot_we = 0, tot_swap = 0, tot_busy = 0;
  int          last_waddr = 0;

  task automatic chk(string name, int got, int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, got, exp);
    end
  endtask

  task automatic monitor();
    int d;
    bit rise, e_busy, e_swap, e_we;
    forever begin
      @(negedge clock);
      cyc++;
      if (!resetn) begin
        m_active = 0; m_fc = 0; m_ov = 0; m_prev = 0;
        chk("rst_busy",  int'(bif.busy), 0);
        chk("rst_swap",  int'(bif.disp_swap), 0);
        chk("rst_we",    int'(bif.disp_we), 0);
        chk("rst_fc",    int'(bif.frame_count), 0);
        chk("rst_ovr",   int'(bif.overrun), 0);
        chk("rst_sel",   int'(bif.boid_sel), 0);
        chk("rst_waddr", int'(bif.disp_waddr), 0);
        continue;
      end
      if (m_active && (cyc - m_s) == m_n + 3) begin
        m_fc     = (m_fc + 1) % 65536;
        m_active = 0;
      end
      d      = cyc - m_s;
      e_busy = m_active && d >= 1 && d <= m_n + 2;
      e_swap = m_active && d == 1;
      e_we   = 0;
      if (m_active && d >= 3 && d <= m_n + 2)
        e_we = int'(m_tab[d-3]) < PIXEL_COUNT;
      chk("busy", int'(bif.busy), int'(e_busy));
      chk("disp_swap", int'(bif.disp_swap), int'(e_swap));
      chk("disp_we", int'(bif.disp_we), int'(e_we));
      if (e_we) chk("disp_waddr", int'(bif.disp_waddr), int'(m_tab[d-3]));
      if (m_active && d >= 1 && d <= m_n + 1)
        chk("boid_sel", int'(bif.boid_sel), (d == 1) ? 0 : d - 2);
      chk("frame_count", int'(bif.frame_count), m_fc);
      chk("overrun", int'(bif.overrun), int'(m_ov));

      if (bif.disp_we)   begin tot_we++; last_waddr = int'(bif.disp_waddr); end
      if (bif.disp_swap) tot_swap++;
      if (bif.busy)      tot_busy++;

      rise = bif.screen_end && !m_prev;
      if (rise && m_active)      m_ov = 1;
      else if (bif.overrun_clr)  m_ov = 0;
      if (rise && !m_active) begin
        m_active = 1;
        m_s      = cyc;
        m_n      = (int'(bif.num_boids) > 16) ? 16 : int'(bif.num_boids);
        for (int k = 0; k < 16; k++) m_tab[k] = addr_tab[k];
      end
      m_prev = bif.screen_end;
    end
  endtask

  task automatic tick(int k);
    repeat (k) begin @(posedge clock); #1; end
  endtask

  task automatic frame(int nb);
    bif.num_boids  = 5'(nb);
    bif.screen_end = 1'b1;
    tick(1);
    bif.screen_end = 1'b0;
  endtask

  initial begin
    int s_we, s_sw, s_b, nb;
    resetn          = 1'b0;
    bif.screen_end  = 1'b0;
    bif.num_boids   = '0;
    bif.overrun_clr = 1'b0;
    for (int k = 0; k < 16; k++) addr_tab[k] = 20'(k * 641);
    fork monitor(); join_none
    tick(3);
    resetn = 1'b1;
    tick(2);

    // Full 16-boid frame.
    s_we = tot_we; s_sw = tot_swap; s_b = tot_busy;
    frame(16); tick(20);
    chk("t1_writes", tot_we - s_we, 16);
    chk("t1_swaps", tot_swap - s_sw, 1);
    chk("t1_busy_cycles", tot_busy - s_b, 18);
    chk("t1_last_waddr", last_waddr, 9615);
    chk("t1_frame_count", int'(bif.frame_count), 1);

    // Out-of-range boid 1 is skipped.
    addr_tab[1] = 20'd307200;
    s_we = tot_we; s_b = tot_busy;
    frame(3); tick(6);
    chk("t2_writes", tot_we - s_we, 2);
    chk("t2_busy_cycles", tot_busy - s_b, 5);
    chk("t2_last_waddr", last_waddr, 1282);
    chk("t2_frame_count", int'(bif.frame_count), 2);
    addr_tab[1] = 20'd641;

    // Empty frame still swaps.
    s_we = tot_we; s_sw = tot_swap; s_b = tot_busy;
    frame(0); tick(4);
    chk("t3_writes", tot_we - s_we, 0);
    chk("t3_swaps", tot_swap - s_sw, 1);
    chk("t3_busy_cycles", tot_busy - s_b, 2);
    chk("t3_frame_count", int'(bif.frame_count), 3);

    // Second edge mid-scan.
    s_we = tot_we; s_sw = tot_swap;
    frame(16); tick(4);
    bif.screen_end = 1'b1; tick(1); bif.screen_end = 1'b0;
    tick(16);
    chk("t4_overrun_set", int'(bif.overrun), 1);
    chk("t4_swaps", tot_swap - s_sw, 1);
    chk("t4_writes", tot_we - s_we, 16);
    chk("t4_frame_count", int'(bif.frame_count), 4);
    bif.overrun_clr = 1'b1; tick(1); bif.overrun_clr = 1'b0; tick(1);
    chk("t4_overrun_clr", int'(bif.overrun), 0);

    // Held-high frame strobe.
    s_sw = tot_swap;
    bif.num_boids  = 5'd16;
    bif.screen_end = 1'b1; tick(100); bif.screen_end = 1'b0;
    chk("t5_held_swaps", tot_swap - s_sw, 1);
    chk("t5_held_frames", int'(bif.frame_count), 5);
    tick(2);
    frame(16); tick(20);
    chk("t5_second_frame", int'(bif.frame_count), 6);

    // Reset in the middle of a scan.
    frame(16); tick(8);
    chk("t6_sel_before_reset", int'(bif.boid_sel), 7);
    #2 resetn = 1'b0;
    #1;
    chk("t6_async_busy", int'(bif.busy), 0);
    chk("t6_async_we", int'(bif.disp_we), 0);
    chk("t6_async_sel", int'(bif.boid_sel), 0);
    chk("t6_async_fc", int'(bif.frame_count), 0);
    tick(2); resetn = 1'b1; tick(2);
    frame(16);
    chk("t6_restart_sel", int'(bif.boid_sel), 0);
    chk("t6_restart_swap", int'(bif.disp_swap), 1);
    tick(19);
    chk("t6_restart_fc", int'(bif.frame_count), 1);

    // Random frames with stray edges, clears and boid-count churn.
    for (int it = 0; it < 40; it++) begin
      for (int k = 0; k < 16; k++)
        addr_tab[k] = ($urandom_range(0, 3) == 0) ? 20'($urandom_range(307200, 1048575))
                                                  : 20'($urandom_range(0, 307199));
      nb = $urandom_range(0, 16);
      frame(nb);
      for (int t = 0; t < nb + 4; t++) begin
        bif.screen_end  = ($urandom_range(0, 7) == 0);
        bif.overrun_clr = ($urandom_range(0, 5) == 0);
        bif.num_boids   = 5'($urandom_range(0, 16));
        tick(1);
      end
      bif.screen_end  = 1'b0;
      bif.overrun_clr = 1'b0;
      tick(22);
    end

    tick(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
